// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, mode and state encodings for the PWM path.
// Used by pwm_period_timer and pwm_duty_sequencer.
package pwm_pkg;

    localparam int DUTY_W_DEF = 4;
    localparam int RATE_W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_TRI  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_UP   = 2'b10,
        ST_DOWN = 2'b11
    } state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running 2^W period counter with end/start markers.
// Shareable with the PWM compare stage so both stay phase-aligned.
module pwm_period_timer #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic reset,
    output logic period_end,
    output logic period_start
);

    logic [W-1:0] count;

    assign period_end = (count == {W{1'b1}});

    // Counter wraps every 2^W cycles; period_start trails period_end by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            period_start <= 1'b0;
        end else begin
            count        <= count + 1'b1;
            period_start <= period_end;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: duty word generator (hold/ramp/triangle) for the PWM stage.
// Optional PWM_SEQ_WRAP_EN: UP/DOWN wrap past the target into a sawtooth.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_load,
    input  logic [1:0]        cfg_mode,
    input  logic [DUTY_W-1:0] cfg_target,
    input  logic [RATE_W-1:0] cfg_rate,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              period_start,
    output logic              step_pulse,
    output logic              at_limit,
    output logic              cfg_pending
);

    logic              period_end;
    logic              apply;
    mode_t             sh_mode, act_mode, in_mode, eff_mode;
    logic [DUTY_W-1:0] sh_target, act_target, in_target, eff_target;
    logic [RATE_W-1:0] sh_rate, act_rate, in_rate;
    state_t            state, state_nx;
    logic [DUTY_W-1:0] duty_nx;
    logic [RATE_W-1:0] rate_cnt, rate_nx;
    logic              tri_on, tri_nx, step_nx;

    pwm_period_timer #(.W(DUTY_W)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .period_end   (period_end),
        .period_start (period_start)
    );

    // A strobe coinciding with period_end bypasses straight into the active copy.
    assign in_mode    = cfg_load ? mode_t'(cfg_mode) : sh_mode;
    assign in_target  = cfg_load ? cfg_target : sh_target;
    assign in_rate    = cfg_load ? cfg_rate : sh_rate;
    assign apply      = period_end & (cfg_pending | cfg_load);
    assign eff_mode   = apply ? in_mode : act_mode;
    assign eff_target = apply ? in_target : act_target;

    // Shadow capture and boundary-aligned transfer to the active config.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_mode     <= MODE_HOLD;
            sh_target   <= '0;
            sh_rate     <= '0;
            act_mode    <= MODE_HOLD;
            act_target  <= '0;
            act_rate    <= '0;
            cfg_pending <= 1'b0;
        end else begin
            sh_mode     <= in_mode;
            sh_target   <= in_target;
            sh_rate     <= in_rate;
            cfg_pending <= ~period_end & (cfg_pending | cfg_load);
            if (apply) begin
                act_mode   <= in_mode;
                act_target <= in_target;
                act_rate   <= in_rate;
            end
        end
    end

    // Sequencer state register; all updates land on period boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            duty_cycle <= '0;
            rate_cnt   <= '0;
            tri_on     <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            duty_cycle <= duty_nx;
            rate_cnt   <= rate_nx;
            tri_on     <= tri_nx;
            step_pulse <= step_nx;
        end
    end

    // Next state: idle on disable, restart on new config or wake, else step.
    always_comb begin
        state_nx = state;
        duty_nx  = duty_cycle;
        rate_nx  = rate_cnt;
        tri_nx   = tri_on;
        step_nx  = 1'b0;
        if (period_end) begin
            if (!enable) begin
                state_nx = ST_IDLE;
                duty_nx  = '0;
                rate_nx  = '0;
                tri_nx   = 1'b0;
            end else if (state == ST_IDLE || apply) begin
                rate_nx = '0;
                tri_nx  = (eff_mode == MODE_TRI);
                unique case (eff_mode)
                    MODE_HOLD: begin
                        state_nx = ST_HOLD;
                        duty_nx  = eff_target;
                    end
                    MODE_UP, MODE_TRI: begin
                        state_nx = ST_UP;
                        duty_nx  = '0;
                    end
                    MODE_DOWN: begin
                        state_nx = ST_DOWN;
                        duty_nx  = '1;
                    end
                    default: ;
                endcase
            end else if (rate_cnt != act_rate) begin
                rate_nx = rate_cnt + 1'b1;
            end else begin
                rate_nx = '0;
                unique case (state)
                    ST_UP: begin
                        if (duty_cycle < act_target) begin
                            duty_nx = duty_cycle + 1'b1;
                        end else if (tri_on) begin
                            if (act_target != '0) begin
                                state_nx = ST_DOWN;
                                duty_nx  = duty_cycle - 1'b1;
                            end
                        end else begin
`ifdef PWM_SEQ_WRAP_EN
                            duty_nx = '0;
`else
                            duty_nx = duty_cycle;
`endif
                        end
                    end
                    ST_DOWN: begin
                        if (tri_on) begin
                            if (duty_cycle != '0) begin
                                duty_nx = duty_cycle - 1'b1;
                            end else if (act_target != '0) begin
                                state_nx = ST_UP;
                                duty_nx  = duty_cycle + 1'b1;
                            end
                        end else if (duty_cycle > act_target) begin
                            duty_nx = duty_cycle - 1'b1;
                        end else begin
`ifdef PWM_SEQ_WRAP_EN
                            duty_nx = '1;
`else
                            duty_nx = duty_cycle;
`endif
                        end
                    end
                    default: ;
                endcase
                step_nx = (duty_nx != duty_cycle);
            end
        end
    end

    // Endpoint flag: target for ramps, target or zero for triangle.
    always_comb begin
        at_limit = 1'b0;
        unique case (state)
            ST_HOLD: at_limit = 1'b1;
            ST_UP, ST_DOWN:
                at_limit = (duty_cycle == act_target)
                         | (tri_on & (duty_cycle == '0));
            default: at_limit = 1'b0;
        endcase
    end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Upstream stage of the 4-bit PWM generator. Produces the `duty_cycle` word that the PWM compare consumes.
- Runs its own period counter, phase-aligned to the PWM counter (both start at 0 out of reset), so duty changes only at period boundaries. This guarantees glitch-free pulses.
- Supports hold, ramp-up, ramp-down and triangle (fade) sequences. Step rate is programmable in whole PWM periods.

Parameters:
- DUTY_W, 4, width of duty word and period counter; period = 2^DUTY_W cycles.
- RATE_W, 4, width of the rate field; periods per step = rate+1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, run sequencer; low = idle, duty forced 0.
- cfg_load, input, 1, one-cycle strobe; capture cfg_mode, cfg_target and cfg_rate into the shadow registers.
- cfg_mode, input, 2, 00 HOLD, 01 UP, 10 DOWN, 11 TRI.
- cfg_target, input, DUTY_W, hold value or ramp limit.
- cfg_rate, input, RATE_W, periods per step minus 1.
- duty_cycle, output, DUTY_W, registered duty word to the PWM.
- period_start, output, 1, pulse in the cycle the period counter equals 0.
- step_pulse, output, 1, pulse in the cycle duty_cycle changes due to a step.
- at_limit, output, 1, high while duty_cycle equals the current sequence endpoint.
- cfg_pending, output, 1, shadow config written but not yet applied.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - duty_cycle=0, period_start=0, step_pulse=0, at_limit=0, cfg_pending=0.
  - Period counter=0, rate counter=0, state=IDLE.
  - Shadow and active config = HOLD / target 0 / rate 0.
- Period counter:
  - Free-runs 0..2^DUTY_W-1 and wraps, whenever reset is low, regardless of enable.
  - period_end = counter at its max value.
  - period_start is a registered pulse, high the cycle after period_end.
- Config:
  - cfg_load writes the shadow registers and sets cfg_pending.
  - At period_end the shadow is copied to active and cfg_pending clears. Any cfg_load in the same cycle as period_end is included in that copy (bypass).
  - A new active config restarts the sequence and clears the rate counter.
  - Back-to-back cfg_loads: the last one wins.
- States: IDLE, HOLD, UP, DOWN.
  - TRI is realised as UP/DOWN with a tri flag set.
  - IDLE -> mode state at the first period_end with enable=1.
  - Any state -> IDLE at the first period_end with enable=0.
  - duty_cycle is 0 in IDLE.
- Entry (restart) values, loaded into duty_cycle at the period_end that starts the sequence:
  - HOLD: target.
  - UP: 0.
  - DOWN: all-ones.
  - TRI: 0, state UP.
- Stepping:
  - The rate counter increments at each period_end while running.
  - When rate counter == rate, the counter clears and one step occurs. duty_cycle updates at that same period_end; step_pulse fires in the following cycle.
  - UP: duty+1, saturates at target.
  - DOWN: duty-1, saturates at target.
  - TRI: UP until target, then DOWN until 0, repeat.
  - A step that produces no change (saturated, or HOLD) gives no step_pulse.
- at_limit (combinational from duty/state):
  - UP/DOWN: high when duty==target.
  - TRI: high when duty==target or duty==0.
  - HOLD: always high.
  - IDLE: always low.
- Edge cases:
  - target=0 in TRI: duty stays 0.
  - UP with target=0: at_limit immediately.
  - DOWN with target=all-ones: at_limit immediately.
  - rate=0: step every period.
  - enable toggling mid-period: takes effect only at period_end.
- Arithmetic: unsigned DUTY_W-bit, never wraps (except under the optional feature).

Optional Feature:
- Macro: PWM_SEQ_WRAP_EN.
- Defined: in UP, a step from target goes to 0; in DOWN, a step from target goes to all-ones. This gives a sawtooth, with step_pulse firing on each wrap. TRI is unchanged.
- Undefined: UP and DOWN saturate as specified in Behaviour.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W / RATE_W defaults.
  - Mode enum: MODE_HOLD, MODE_UP, MODE_DOWN, MODE_TRI.
  - State enum: ST_IDLE, ST_HOLD, ST_UP, ST_DOWN.
- One sub-module: pwm_period_timer (period counter plus period_end/period_start). It can later be shared with the PWM stage to guarantee phase alignment.

Test Plan:
- Reset mid-run with duty=7 -> next cycle duty_cycle=0, cfg_pending=0, period counter=0.
- enable=1, load HOLD target=5 -> cfg_pending high until the first period_end, then duty_cycle=5, at_limit=1, step_pulse never fires.
- UP target=3 rate=1 -> duty 0,1,2,3, changing every 32 cycles; each change is followed one cycle later by step_pulse; stays 3 with at_limit=1.
- TRI target=2 rate=0 -> duty 0,1,2,1,0,1,2… changing every 16 cycles; at_limit high at 0 and at 2.
- cfg_load in the same cycle as period_end (DOWN target=12) -> applied at that boundary, duty_cycle=15 next cycle, cfg_pending never visible high.
- With PWM_SEQ_WRAP_EN, UP target=2 rate=0 -> duty 0,1,2,0,1,2…; without the macro -> saturates at 2.
